alu_share_arb: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_share_arb_rr_arbiter.sv | 41 ++++
 rtl/alu_share_arb.sv | 156 +++++++++++++++
 tb/tb_alu_share_arb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: one-hot opt codes, default
// widths, arbiter FSM states and the multi-hot opt helper.
package alu_pkg;

  localparam int XLEN  = 32;
  localparam int OPT_W = 10;

  localparam logic [OPT_W-1:0] ALU_ADD  = 10'b00_0000_0001;
  localparam logic [OPT_W-1:0] ALU_SUB  = 10'b00_0000_0010;
  localparam logic [OPT_W-1:0] ALU_SLL  = 10'b00_0000_0100;
  localparam logic [OPT_W-1:0] ALU_SLT  = 10'b00_0000_1000;
  localparam logic [OPT_W-1:0] ALU_SLTU = 10'b00_0001_0000;
  localparam logic [OPT_W-1:0] ALU_XOR  = 10'b00_0010_0000;
  localparam logic [OPT_W-1:0] ALU_SRL  = 10'b00_0100_0000;
  localparam logic [OPT_W-1:0] ALU_OR   = 10'b00_1000_0000;
  localparam logic [OPT_W-1:0] ALU_AND  = 10'b01_0000_0000;
  localparam logic [OPT_W-1:0] ALU_SRA  = 10'b10_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // More than one bit set; the all-zero opt is not multi-hot.
  function automatic logic opt_multi_hot(input logic [OPT_W-1:0] opt);
    return (opt & (opt - 10'd1)) != 10'd0;
  endfunction

endpackage

// File: rtl/alu_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requesting index at or above
// i_ptr wins (wrapping); grant is forced to zero when i_en is low.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [NREQ-1:0]   w_rot_grant;
  logic [2*NREQ-1:0] w_unrot;
  logic              w_found;

  // Rotate so the pointer position sits at bit 0, pick first set, rotate back.
  always_comb begin
    w_dbl       = {i_req, i_req} >> i_ptr;
    w_rot       = w_dbl[NREQ-1:0];
    w_rot_grant = '0;
    w_found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_rot_grant[k] = 1'b1;
        w_found        = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
    w_unrot = {w_rot_grant, w_rot_grant} << i_ptr;
    if (i_en) begin
      o_grant = w_unrot[2*NREQ-1:NREQ];
    end else begin
      o_grant = '0;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between NREQ requesters with
// round-robin arbitration. Optional illegal-opt check: ALU_OPT_CHECK_EN.
module alu_share_arb #(
  parameter int NREQ  = 2,
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int OPT_W = alu_pkg::OPT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*XLEN-1:0]  req_src1,
  input  logic [NREQ*XLEN-1:0]  req_src2,
  input  logic [NREQ*OPT_W-1:0] req_opt,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [XLEN-1:0]       resp_res,
  output logic                  resp_err,
  output logic [XLEN-1:0]       alu_src1,
  output logic [XLEN-1:0]       alu_src2,
  output logic [OPT_W-1:0]      alu_opt,
  input  logic [XLEN-1:0]       alu_res
);

  import alu_pkg::*;

  localparam int PW = (NREQ > 2) ? 2 : 1;

  arb_state_t        r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic              r_illegal;
  logic [NREQ-1:0]   r_resp_valid;
  logic [XLEN-1:0]   r_resp_res;
  logic              r_resp_err;
  logic [XLEN-1:0]   r_alu_src1;
  logic [XLEN-1:0]   r_alu_src2;
  logic [OPT_W-1:0]  r_alu_opt;

  logic [NREQ-1:0]   w_grant;
  logic              w_arb_en;
  logic              w_owner_ready;
  logic              w_accept;
  logic [PW-1:0]     w_gidx;
  logic [PW-1:0]     w_ptr_next;
  logic [XLEN-1:0]   w_src1_sel;
  logic [XLEN-1:0]   w_src2_sel;
  logic [OPT_W-1:0]  w_opt_sel;
  logic              w_illegal;
  logic [NREQ-1:0]   w_owner_onehot;

  assign w_owner_ready  = resp_ready[r_owner];
  assign w_arb_en       = (r_state == IDLE) || ((r_state == RESP) && w_owner_ready);
  assign w_accept       = |w_grant;
  assign w_owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant)
  );

  // Encode the one-hot grant and select the winner's payload.
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gidx = PW'(i);
      end else begin
        w_gidx = w_gidx;
      end
    end
    if (w_gidx == PW'(NREQ - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_gidx + PW'(1);
    end
    w_src1_sel = req_src1[w_gidx*XLEN +: XLEN];
    w_src2_sel = req_src2[w_gidx*XLEN +: XLEN];
    w_opt_sel  = req_opt[w_gidx*OPT_W +: OPT_W];
`ifdef ALU_OPT_CHECK_EN
    w_illegal  = opt_multi_hot(w_opt_sel);
`else
    w_illegal  = 1'b0;
`endif
  end

  // Arbiter FSM with operand, opt and response buffers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_illegal    <= 1'b0;
      r_resp_valid <= '0;
      r_resp_res   <= '0;
      r_resp_err   <= 1'b0;
      r_alu_src1   <= '0;
      r_alu_src2   <= '0;
      r_alu_opt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= w_accept ? EXEC : IDLE;
        end
        EXEC: begin
          r_resp_res   <= r_illegal ? {XLEN{1'b0}} : alu_res;
          r_resp_err   <= r_illegal;
          r_resp_valid <= w_owner_onehot;
          r_state      <= RESP;
        end
        RESP: begin
          if (w_owner_ready) begin
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            r_state      <= w_accept ? EXEC : IDLE;
            if (!w_accept) begin
              r_alu_opt <= '0;
            end else begin
              r_alu_opt <= r_alu_opt;
            end
          end else begin
            r_state <= RESP;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // An accepted op loads the ALU registers; illegal opts drive a zero opt.
      if (w_accept) begin
        r_alu_src1 <= w_src1_sel;
        r_alu_src2 <= w_src2_sel;
        r_alu_opt  <= w_illegal ? {OPT_W{1'b0}} : w_opt_sel;
        r_illegal  <= w_illegal;
        r_owner    <= w_gidx;
        r_ptr      <= w_ptr_next;
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  assign req_ready  = w_grant;
  assign resp_valid = r_resp_valid;
  assign resp_res   = r_resp_res;
  assign resp_err   = r_resp_err;
  assign alu_src1   = r_alu_src1;
  assign alu_src2   = r_alu_src2;
  assign alu_opt    = r_alu_opt;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU driving alu_res.
// Extra illegal-opt checks are built when ALU_OPT_CHECK_EN is defined.
module tb_alu_share_arb;

  import alu_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic [19:0] req_opt;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_res;
  logic        resp_err;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [9:0]  alu_opt;
  logic [31:0] alu_res;

  int checks;
  int failures;

  alu_share_arb #(.NREQ(2), .XLEN(32), .OPT_W(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_opt    (req_opt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_res   (resp_res),
    .resp_err   (resp_err),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_opt    (alu_opt),
    .alu_res    (alu_res)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference ALU outside the DUT.
  always_comb begin
    case (alu_opt)
      ALU_ADD:  alu_res = alu_src1 + alu_src2;
      ALU_SUB:  alu_res = alu_src1 - alu_src2;
      ALU_SLL:  alu_res = alu_src1 << alu_src2[4:0];
      ALU_SLT:  alu_res = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      ALU_SLTU: alu_res = {31'd0, alu_src1 < alu_src2};
      ALU_XOR:  alu_res = alu_src1 ^ alu_src2;
      ALU_SRL:  alu_res = alu_src1 >> alu_src2[4:0];
      ALU_OR:   alu_res = alu_src1 | alu_src2;
      ALU_AND:  alu_res = alu_src1 & alu_src2;
      ALU_SRA:  alu_res = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
      default:  alu_res = 32'd0;
    endcase
  end

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [9:0] op);
    req_src1[idx*32 +: 32] = s1;
    req_src2[idx*32 +: 32] = s2;
    req_opt[idx*10 +: 10]  = op;
    req_valid[idx]         = 1'b1;
  endtask

  // Issue one op, hold the response until sampled; bounded waits.
  task automatic run_op(input int idx, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [9:0] op, output logic [31:0] res, output logic err,
                        output logic [1:0] vld, output logic [9:0] exec_opt);
    int n;
    @(negedge clock);
    resp_ready = 2'b00;
    set_req(idx, s1, s2, op);
    #1;
    n = 0;
    while (req_ready[idx] !== 1'b1 && n < 20) begin
      @(negedge clock); #1; n++;
    end
    @(negedge clock);
    req_valid = 2'b00;
    exec_opt = alu_opt;
    n = 0;
    while (resp_valid === 2'b00 && n < 20) begin
      @(negedge clock); n++;
    end
    res = resp_res; err = resp_err; vld = resp_valid;
    resp_ready = 2'b11;
    @(negedge clock);
    resp_ready = 2'b00;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({req_ready, resp_valid, resp_err} !== 5'b0 || resp_res !== 32'd0 ||
        alu_src1 !== 32'd0 || alu_src2 !== 32'd0 || alu_opt !== 10'd0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b err=%b res=%h s1=%h s2=%h opt=%h expected all zero",
               req_ready, resp_valid, resp_err, resp_res, alu_src1, alu_src2, alu_opt);
    end
  endtask

  task automatic test_single();
    apply_reset();
    resp_ready = 2'b11;
    set_req(0, 32'd5, 32'd7, ALU_ADD);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL single_grant: got %b expected 01", req_ready);
    end
    @(negedge clock);
    req_valid = 2'b00;
    checks++;
    if (resp_valid !== 2'b00 || alu_src1 !== 32'd5 || alu_src2 !== 32'd7 || alu_opt !== ALU_ADD) begin
      failures++;
      $display("FAIL single_exec: vld=%b s1=%h s2=%h opt=%h expected 00/5/7/001",
               resp_valid, alu_src1, alu_src2, alu_opt);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 2'b01 || resp_res !== 32'd12 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_resp: vld=%b res=%0d err=%b expected 01/12/0", resp_valid, resp_res, resp_err);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 2'b00 || alu_opt !== 10'd0) begin
      failures++;
      $display("FAIL single_idle: vld=%b opt=%h expected 00/000", resp_valid, alu_opt);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    resp_ready = 2'b11;
    set_req(0, 32'd10, 32'd3, ALU_SUB);
    set_req(1, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL cont_grant0: got %b expected 01", req_ready);
    end
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b00 || alu_opt !== ALU_SUB) begin
      failures++; $display("FAIL cont_exec0: rdy=%b opt=%h expected 00/002", req_ready, alu_opt);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 2'b01 || resp_res !== 32'd7 || req_ready !== 2'b10) begin
      failures++;
      $display("FAIL cont_resp0: vld=%b res=%0d rdy=%b expected 01/7/10", resp_valid, resp_res, req_ready);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 2'b00 || alu_opt !== ALU_SLT) begin
      failures++; $display("FAIL cont_exec1: vld=%b opt=%h expected 00/008", resp_valid, alu_opt);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 2'b10 || resp_res !== 32'd1 || req_ready !== 2'b01) begin
      failures++;
      $display("FAIL cont_resp1: vld=%b res=%0d rdy=%b expected 10/1/01", resp_valid, resp_res, req_ready);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (resp_valid !== 2'b01 || resp_res !== 32'd7) begin
      failures++; $display("FAIL cont_resp2: vld=%b res=%0d expected 01/7", resp_valid, resp_res);
    end
    req_valid = 2'b00;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    int bad;
    apply_reset();
    resp_ready = 2'b00;
    set_req(0, 32'd1, 32'd4, ALU_SLL);
    @(negedge clock);
    req_valid = 2'b00;
    set_req(1, 32'd2, 32'd3, ALU_ADD);
    @(negedge clock);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid !== 2'b01 || resp_res !== 32'd16 || req_ready !== 2'b00) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d bad cycles (last vld=%b res=%0d rdy=%b) expected 0", bad,
               resp_valid, resp_res, req_ready);
    end
    resp_ready = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++; $display("FAIL bp_b2b_grant: got %b expected 10", req_ready);
    end
    @(negedge clock);
    req_valid = 2'b00;
    checks++;
    if (resp_valid !== 2'b00 || alu_src1 !== 32'd2 || alu_opt !== ALU_ADD) begin
      failures++;
      $display("FAIL bp_b2b_exec: vld=%b s1=%h opt=%h expected 00/2/001", resp_valid, alu_src1, alu_opt);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 2'b10 || resp_res !== 32'd5) begin
      failures++; $display("FAIL bp_b2b_resp: vld=%b res=%0d expected 10/5", resp_valid, resp_res);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 2'b10 || resp_res !== 32'd5) begin
      failures++; $display("FAIL bp_nonowner_ready: vld=%b res=%0d expected 10/5", resp_valid, resp_res);
    end
    resp_ready = 2'b11;
    @(negedge clock);
    checks++;
    if (resp_valid !== 2'b00 || alu_opt !== 10'd0) begin
      failures++; $display("FAIL bp_release: vld=%b opt=%h expected 00/000", resp_valid, alu_opt);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    apply_reset();
    resp_ready = 2'b11;
    set_req(0, 32'd9, 32'd9, ALU_ADD);
    @(negedge clock);
    req_valid = 2'b00;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (resp_valid !== 2'b00 || resp_res !== 32'd0 || alu_src1 !== 32'd0 || alu_opt !== 10'd0 ||
        req_ready !== 2'b00) begin
      failures++;
      $display("FAIL midop_reset: vld=%b res=%h s1=%h opt=%h rdy=%b expected zeros",
               resp_valid, resp_res, alu_src1, alu_opt, req_ready);
    end
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (resp_valid !== 2'b00) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL midop_no_resp: %0d cycles with resp_valid expected 0", seen);
    end
  endtask

  task automatic test_shifts();
    logic [31:0] res; logic err; logic [1:0] vld; logic [9:0] eo;
    apply_reset();
    run_op(1, 32'h8000_0000, 32'd4, ALU_SRA, res, err, vld, eo);
    checks++;
    if (vld !== 2'b10 || res !== 32'hF800_0000 || err !== 1'b0) begin
      failures++; $display("FAIL sra: vld=%b res=%h err=%b expected 10/f8000000/0", vld, res, err);
    end
    run_op(0, 32'h8000_0000, 32'd4, ALU_SRL, res, err, vld, eo);
    checks++;
    if (vld !== 2'b01 || res !== 32'h0800_0000 || err !== 1'b0) begin
      failures++; $display("FAIL srl: vld=%b res=%h err=%b expected 01/08000000/0", vld, res, err);
    end
  endtask

  task automatic test_opt_check();
    logic [31:0] res; logic err; logic [1:0] vld; logic [9:0] eo;
    apply_reset();
    run_op(0, 32'h1234, 32'h5, 10'h000, res, err, vld, eo);
    checks++;
    if (vld !== 2'b01 || res !== 32'd0 || err !== 1'b0) begin
      failures++; $display("FAIL zero_opt: vld=%b res=%h err=%b expected 01/0/0", vld, res, err);
    end
`ifdef ALU_OPT_CHECK_EN
    run_op(1, 32'd6, 32'd2, 10'h003, res, err, vld, eo);
    checks++;
    if (vld !== 2'b10 || res !== 32'd0 || err !== 1'b1 || eo !== 10'd0) begin
      failures++;
      $display("FAIL illegal_opt: vld=%b res=%h err=%b exec_opt=%h expected 10/0/1/000", vld, res, err, eo);
    end
    run_op(0, 32'd6, 32'd2, ALU_ADD, res, err, vld, eo);
    checks++;
    if (vld !== 2'b01 || res !== 32'd8 || err !== 1'b0) begin
      failures++; $display("FAIL after_illegal: vld=%b res=%0d err=%b expected 01/8/0", vld, res, err);
    end
`endif
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    req_src1 = 64'd0; req_src2 = 64'd0; req_opt = 20'd0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_shifts();
    test_opt_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
